// File: rtl/bcd_rtc_clock.sv
// BCD real-time clock with tick prescaler, run-time 12/24-hour mode, validated load and hh:mm alarm.
// Time is packed BCD throughout; all outputs come straight from registers.
module bcd_rtc_clock #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick,
    output logic       alarm,
    output logic       load_err
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             mode_q, nxt_mode;
    logic             pending, nxt_pending;
    logic [7:0]       nxt_hh, nxt_mm, nxt_ss;
    logic             nxt_pm, nxt_tick, nxt_alarm, nxt_err;

    logic             tick_int;
    logic             load_ok;
    logic [6:0]       load_hh_bin, cur_hh_bin;
    logic [7:0]       adv_hh, adv_mm, adv_ss;
    logic             adv_pm, ss_wrap, mm_wrap;

    assign tick_int    = ena && (cnt == CNT_MAX);
    assign load_hh_bin = bcd_to_bin(load_hh);
    assign cur_hh_bin  = bcd_to_bin(hh);

    // Loaded values are judged against the format the clock currently holds
    assign load_ok = is_bcd(load_hh) && is_bcd(load_mm) && is_bcd(load_ss)
                   && (load_mm[7:4] <= 4'd5) && (load_ss[7:4] <= 4'd5)
                   && (mode_q ? (load_hh_bin <= 7'd23)
                              : ((load_hh_bin >= 7'd1) && (load_hh_bin <= 7'd12)));

    // One-second advance of the current time
    always_comb begin
        ss_wrap = (ss == 8'h59);
        mm_wrap = (mm == 8'h59);
        adv_ss  = ss_wrap ? 8'h00 : bcd_inc(ss);
        adv_mm  = mm;
        adv_hh  = hh;
        adv_pm  = pm;
        if (ss_wrap) begin
            adv_mm = mm_wrap ? 8'h00 : bcd_inc(mm);
            if (mm_wrap) begin
                if (mode_q) begin
                    adv_hh = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
                    adv_pm = (adv_hh >= 8'h12);
                end else if (hh == 8'h12) begin
                    adv_hh = 8'h01;
                end else if (hh == 8'h11) begin
                    adv_hh = 8'h12;
                    adv_pm = ~pm;
                end else begin
                    adv_hh = bcd_inc(hh);
                end
            end
        end
    end

    // Next-state selection: load > mode change > second advance
    always_comb begin
        nxt_hh      = hh;
        nxt_mm      = mm;
        nxt_ss      = ss;
        nxt_pm      = pm;
        nxt_mode    = mode_q;
        nxt_pending = pending;
        nxt_tick    = 1'b0;
        nxt_alarm   = 1'b0;
        nxt_err     = 1'b0;
        nxt_cnt     = cnt;

        if (ena) begin
            nxt_cnt = tick_int ? '0 : cnt + CNT_W'(1);
        end

        if (load) begin
            if (load_ok) begin
                nxt_hh      = load_hh;
                nxt_mm      = load_mm;
                nxt_ss      = load_ss;
                nxt_pm      = mode_q ? (load_hh >= 8'h12) : load_pm;
                nxt_cnt     = '0;
                nxt_pending = 1'b0;
            end else begin
                nxt_err = 1'b1;
            end
        end else if (mode_24h != mode_q) begin
            nxt_mode = mode_24h;
            if (tick_int) begin
                nxt_pending = 1'b1;
            end
            if (mode_24h) begin
                if (cur_hh_bin == 7'd12) begin
                    nxt_hh = pm ? 8'h12 : 8'h00;
                end else begin
                    nxt_hh = pm ? bin_to_bcd(cur_hh_bin + 7'd12) : hh;
                end
            end else begin
                if (cur_hh_bin == 7'd0) begin
                    nxt_hh = 8'h12;
                    nxt_pm = 1'b0;
                end else if (cur_hh_bin < 7'd12) begin
                    nxt_pm = 1'b0;
                end else if (cur_hh_bin == 7'd12) begin
                    nxt_pm = 1'b1;
                end else begin
                    nxt_hh = bin_to_bcd(cur_hh_bin - 7'd12);
                    nxt_pm = 1'b1;
                end
            end
        end else if (tick_int || pending) begin
            nxt_hh      = adv_hh;
            nxt_mm      = adv_mm;
            nxt_ss      = adv_ss;
            nxt_pm      = adv_pm;
            nxt_tick    = 1'b1;
            nxt_pending = 1'b0;
            nxt_alarm   = alarm_en && (adv_hh == alarm_hh) && (adv_mm == alarm_mm)
                        && (adv_ss == 8'h00) && (mode_q || (adv_pm == alarm_pm));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hh       <= mode_24h ? 8'h00 : 8'h12;
            mm       <= 8'h00;
            ss       <= 8'h00;
            pm       <= 1'b0;
            mode_q   <= mode_24h;
            pending  <= 1'b0;
            cnt      <= '0;
            tick     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            hh       <= nxt_hh;
            mm       <= nxt_mm;
            ss       <= nxt_ss;
            pm       <= nxt_pm;
            mode_q   <= nxt_mode;
            pending  <= nxt_pending;
            cnt      <= nxt_cnt;
            tick     <= nxt_tick;
            alarm    <= nxt_alarm;
            load_err <= nxt_err;
        end
    end

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Scoreboard bench for bcd_rtc_clock: stimulus pushes expected snapshots, a negedge monitor
// pops one whenever the DUT strobes (tick/alarm/load_err) or the stimulus requests a probe.
module tb_bcd_rtc_clock;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset, ena, mode_24h, load, load_pm, alarm_en, alarm_pm;
    logic [7:0] load_hh, load_mm, load_ss, alarm_hh, alarm_mm;
    logic [7:0] hh, mm, ss;
    logic       pm, tick, alarm, load_err;

    bcd_rtc_clock #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .ena(ena), .mode_24h(mode_24h),
        .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .alarm(alarm), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      nm;
        logic [7:0] hh, mm, ss;
        logic       pm, tick, alarm, err;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic probe = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string nm, input logic [7:0] h, input logic [7:0] m,
                                input logic [7:0] s, input logic p, input logic t,
                                input logic a, input logic er, input int at);
        exp_t r;
        r.nm = nm; r.hh = h; r.mm = m; r.ss = s; r.pm = p;
        r.tick = t; r.alarm = a; r.err = er; r.at = at;
        return r;
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic p);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s; load_pm = p;
        cyc_wait(1);
        load = 1'b0;
    endtask

    task automatic probe_chk(input exp_t x);
        sb.push_back(x);
        probe = 1'b1;
        cyc_wait(1);
        probe = 1'b0;
    endtask

    // Monitor: every strobe or probe consumes exactly one expected snapshot
    always @(negedge clk) begin
        if (probe || tick || alarm || load_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got tick=%0b alarm=%0b load_err=%0b time=%h:%h:%h pm=%0b cyc=%0d, required no event",
                         tick, alarm, load_err, hh, mm, ss, pm, cyc);
            end else begin
                e = sb.pop_front();
                if (hh !== e.hh || mm !== e.mm || ss !== e.ss || pm !== e.pm ||
                    tick !== e.tick || alarm !== e.alarm || load_err !== e.err ||
                    (e.at >= 0 && cyc != e.at)) begin
                    errors++;
                    $display("FAIL %s: got %h:%h:%h pm=%0b tick=%0b alarm=%0b err=%0b cyc=%0d, required %h:%h:%h pm=%0b tick=%0b alarm=%0b err=%0b cyc=%0d",
                             e.nm, hh, mm, ss, pm, tick, alarm, load_err, cyc,
                             e.hh, e.mm, e.ss, e.pm, e.tick, e.alarm, e.err, e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset = 1'b1; ena = 1'b0; mode_24h = 1'b0; load = 1'b0; load_pm = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        alarm_en = 1'b0; alarm_pm = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
        cyc_wait(1);
        probe_chk(mk("reset_12h", 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, -1));

        // Prescaler cadence and ena gating
        reset = 1'b0; ena = 1'b1; base = cyc;
        sb.push_back(mk("first_tick", 8'h12, 8'h00, 8'h01, 0, 1, 0, 0, base + 4));
        sb.push_back(mk("ena_gap_tick", 8'h12, 8'h00, 8'h02, 0, 1, 0, 0, base + 11));
        cyc_wait(6);
        ena = 1'b0; cyc_wait(3);
        ena = 1'b1; cyc_wait(2);
        ena = 1'b0;

        // 12h rollovers
        do_load(8'h11, 8'h59, 8'h58, 1'b0);
        sb.push_back(mk("12h_1159_59", 8'h11, 8'h59, 8'h59, 0, 1, 0, 0, -1));
        sb.push_back(mk("12h_noon", 8'h12, 8'h00, 8'h00, 1, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(8); ena = 1'b0;
        do_load(8'h12, 8'h59, 8'h59, 1'b1);
        sb.push_back(mk("12h_12to01", 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(4); ena = 1'b0;

        // 24h mode and rollovers
        mode_24h = 1'b1; cyc_wait(1);
        probe_chk(mk("conv_01pm_to_13", 8'h13, 8'h00, 8'h00, 1, 0, 0, 0, -1));
        do_load(8'h23, 8'h59, 8'h59, 1'b0);
        sb.push_back(mk("24h_midnight", 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(4); ena = 1'b0;
        do_load(8'h11, 8'h59, 8'h59, 1'b1);
        probe_chk(mk("24h_load_pm_ignored", 8'h11, 8'h59, 8'h59, 0, 0, 0, 0, -1));
        sb.push_back(mk("24h_noon", 8'h12, 8'h00, 8'h00, 1, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(4); ena = 1'b0;

        // Mode conversions
        mode_24h = 1'b0; cyc_wait(1);
        probe_chk(mk("conv_12_to_12pm", 8'h12, 8'h00, 8'h00, 1, 0, 0, 0, -1));
        do_load(8'h12, 8'h30, 8'h00, 1'b0);
        mode_24h = 1'b1; cyc_wait(1);
        probe_chk(mk("conv_12am_to_00", 8'h00, 8'h30, 8'h00, 0, 0, 0, 0, -1));
        mode_24h = 1'b0; cyc_wait(1);
        probe_chk(mk("conv_00_to_12am", 8'h12, 8'h30, 8'h00, 0, 0, 0, 0, -1));

        // Tick coincident with a mode change is deferred by one cycle
        ena = 1'b1; cyc_wait(3);
        mode_24h = 1'b1; cyc_wait(1);
        ena = 1'b0;
        sb.push_back(mk("coincident_conv", 8'h00, 8'h30, 8'h00, 0, 0, 0, 0, cyc));
        sb.push_back(mk("pending_advance", 8'h00, 8'h30, 8'h01, 0, 1, 0, 0, cyc + 1));
        probe = 1'b1; cyc_wait(1); probe = 1'b0;
        mode_24h = 1'b0; cyc_wait(1);
        probe_chk(mk("back_to_12h", 8'h12, 8'h30, 8'h01, 0, 0, 0, 0, -1));

        // Load validation
        sb.push_back(mk("rej_hh13", 8'h12, 8'h30, 8'h01, 0, 0, 0, 1, -1));
        do_load(8'h13, 8'h00, 8'h00, 1'b0);
        sb.push_back(mk("rej_hh00", 8'h12, 8'h30, 8'h01, 0, 0, 0, 1, -1));
        do_load(8'h00, 8'h10, 8'h10, 1'b0);
        sb.push_back(mk("rej_mm60", 8'h12, 8'h30, 8'h01, 0, 0, 0, 1, -1));
        do_load(8'h01, 8'h60, 8'h00, 1'b0);
        sb.push_back(mk("rej_ss5a", 8'h12, 8'h30, 8'h01, 0, 0, 0, 1, -1));
        do_load(8'h01, 8'h00, 8'h5A, 1'b0);
        ena = 1'b1; cyc_wait(2);
        do_load(8'h07, 8'h15, 8'h30, 1'b0);
        base = cyc;
        sb.push_back(mk("load_restarts_prescaler", 8'h07, 8'h15, 8'h31, 0, 1, 0, 0, base + 4));
        cyc_wait(4); ena = 1'b0;

        // Alarm
        alarm_hh = 8'h07; alarm_mm = 8'h16; alarm_pm = 1'b0; alarm_en = 1'b1;
        do_load(8'h07, 8'h15, 8'h59, 1'b0);
        sb.push_back(mk("alarm_hit", 8'h07, 8'h16, 8'h00, 0, 1, 1, 0, -1));
        sb.push_back(mk("alarm_one_shot", 8'h07, 8'h16, 8'h01, 0, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(8); ena = 1'b0;
        alarm_en = 1'b0;
        do_load(8'h07, 8'h15, 8'h59, 1'b0);
        sb.push_back(mk("alarm_disabled", 8'h07, 8'h16, 8'h00, 0, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(4); ena = 1'b0;
        alarm_en = 1'b1; alarm_pm = 1'b1;
        do_load(8'h07, 8'h15, 8'h59, 1'b0);
        sb.push_back(mk("alarm_pm_mismatch", 8'h07, 8'h16, 8'h00, 0, 1, 0, 0, -1));
        ena = 1'b1; cyc_wait(4); ena = 1'b0;
        alarm_pm = 1'b0;
        do_load(8'h07, 8'h16, 8'h00, 1'b0);
        probe_chk(mk("alarm_not_on_load", 8'h07, 8'h16, 8'h00, 0, 0, 0, 0, -1));

        // Reset mid-count into 24h mode
        ena = 1'b1; cyc_wait(2);
        reset = 1'b1; mode_24h = 1'b1; cyc_wait(1);
        probe_chk(mk("reset_24h", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, -1));
        reset = 1'b0; base = cyc;
        sb.push_back(mk("tick_after_reset", 8'h00, 8'h00, 8'h01, 0, 1, 0, 0, base + 4));
        cyc_wait(4); ena = 1'b0;

        cyc_wait(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
